// File: rtl/spi_midi_cmd_decoder.sv
// spi_midi_cmd_decoder: parses MIDI command bytes into a show-ahead command FIFO
module spi_midi_cmd_decoder #(
  parameter int NUM_VOICES = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int VOICE_W = $clog2(NUM_VOICES) < 1 ? 1 : $clog2(NUM_VOICES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte,
  output logic               o_cmd_valid,
  input  logic               i_cmd_ready,
  output logic [1:0]         o_cmd_type,
  output logic [VOICE_W-1:0] o_cmd_voice,
  output logic [6:0]         o_cmd_data0,
  output logic [6:0]         o_cmd_data1,
  output logic               o_overflow,
  output logic [7:0]         o_err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = 16 + VOICE_W;
  typedef enum logic [1:0] {IDLE, VOICE, DATA0, DATA1} state_t;
  state_t state, state_n;
  logic [1:0] typ, typ_n;
  logic [VOICE_W-1:0] voice, voice_n;
  logic [6:0] d0, d0_n, d1, d1_n;
  logic [TW-1:0] cnt;
  logic push, err, timeout, rec, pop, full, wr, ovf;
  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wp;
  logic [AW:0] count;
  assign rec = i_byte == 8'h90 || i_byte == 8'h80 || i_byte == 8'hE0 || i_byte == 8'hB0;
  always_comb begin
    state_n = state;
    typ_n = typ;
    voice_n = voice;
    d0_n = d0;
    d1_n = d1;
    push = 1'b0;
    err = 1'b0;
    timeout = state != IDLE && !i_byte_valid && cnt == TW'(TIMEOUT_CYCLES - 1);
    if (timeout) begin
      err = 1'b1;
      state_n = IDLE;
    end else if (i_byte_valid && (state == IDLE || i_byte[7])) begin
      // a status byte mid-packet aborts it and is then treated as a fresh IDLE byte
      err = state != IDLE;
      state_n = IDLE;
      voice_n = '0;
      d0_n = '0;
      d1_n = '0;
      if (rec) begin
        typ_n = i_byte == 8'h90 ? 2'd0 : i_byte == 8'h80 ? 2'd1 : i_byte == 8'hE0 ? 2'd2 : 2'd3;
        push = i_byte == 8'hB0;
        state_n = i_byte == 8'hB0 ? IDLE : VOICE;
      end
    end else if (i_byte_valid) begin
      case (state)
        VOICE: begin
          err = int'(i_byte) >= NUM_VOICES;
          voice_n = i_byte[VOICE_W-1:0];
          push = !err && typ == 2'd1;
          state_n = err || typ == 2'd1 ? IDLE : DATA0;
        end
        DATA0: begin
          d0_n = i_byte[6:0];
          state_n = DATA1;
        end
        default: begin
          d1_n = i_byte[6:0];
          push = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end
  assign o_cmd_valid = count != '0;
  assign pop = o_cmd_valid && i_cmd_ready;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign wr = push && (!full || pop);
  assign ovf = push && !wr;
  assign {o_cmd_type, o_cmd_voice, o_cmd_data0, o_cmd_data1} = o_cmd_valid ? mem[rd] : '0;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      typ <= '0;
      voice <= '0;
      d0 <= '0;
      d1 <= '0;
      cnt <= '0;
      rd <= '0;
      wp <= '0;
      count <= '0;
      o_overflow <= 1'b0;
      o_err_count <= '0;
    end else begin
      state <= state_n;
      typ <= typ_n;
      voice <= voice_n;
      d0 <= d0_n;
      d1 <= d1_n;
      cnt <= i_byte_valid ? '0 : state != IDLE ? cnt + 1'b1 : cnt;
      if (wr) begin
        mem[wp] <= {typ_n, voice_n, d0_n, d1_n};
        wp <= wp + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      o_overflow <= o_overflow | ovf;
      if ((err || ovf) && o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_midi_cmd_decoder.sv
// tb_spi_midi_cmd_decoder: directed and random byte streams checked by a packet-level model and scoreboard
module tb_spi_midi_cmd_decoder;
  localparam int NV = 16;
  localparam int D = 4;
  localparam int TO = 20;
  logic clk = 0;
  logic i_reset = 1;
  logic i_byte_valid = 0;
  logic [7:0] i_byte = 0;
  logic i_cmd_ready = 0;
  logic o_cmd_valid, o_overflow;
  logic [1:0] o_cmd_type;
  logic [3:0] o_cmd_voice;
  logic [6:0] o_cmd_data0, o_cmd_data1;
  logic [7:0] o_err_count;
  logic [19:0] got, mon_exp;
  logic [19:0] expq[$];
  logic [7:0] pkt[$];
  int n_chk = 0, n_fail = 0, mocc = 0, err_exp = 0, gap = 0;
  logic ovf_exp = 0, rdy = 0;

  spi_midi_cmd_decoder #(.NUM_VOICES(NV), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_type(o_cmd_type),
    .o_cmd_voice(o_cmd_voice), .o_cmd_data0(o_cmd_data0), .o_cmd_data1(o_cmd_data1),
    .o_overflow(o_overflow), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;
  assign got = {o_cmd_type, o_cmd_voice, o_cmd_data0, o_cmd_data1};

  always @(negedge clk) begin
    if (!i_reset && o_cmd_valid && i_cmd_ready) begin
      n_chk++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cmd: got %h, expected no command", got);
      end else begin
        mon_exp = expq.pop_front();
        if (got !== mon_exp) begin
          n_fail++;
          $display("FAIL cmd: got %h, expected %h", got, mon_exp);
        end
      end
    end
  end

  function automatic int plen(input logic [7:0] s);
    return s == 8'h90 || s == 8'hE0 ? 4 : s == 8'h80 ? 2 : s == 8'hB0 ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] b);
    logic pop, e, done;
    logic [19:0] c;
    logic [1:0] t;
    i_byte_valid = v;
    i_byte = b;
    i_cmd_ready = rdy;
    pop = mocc > 0 && rdy;
    e = 0;
    done = 0;
    c = '0;
    if (!v) begin
      gap++;
      if (gap == TO && pkt.size() > 0) begin
        e = 1;
        pkt.delete();
      end
    end else begin
      gap = 0;
      if (b[7]) begin
        if (pkt.size() > 0) e = 1;
        pkt.delete();
        if (plen(b) > 0) pkt.push_back(b);
      end else if (pkt.size() == 1 && int'(b) >= NV) begin
        e = 1;
        pkt.delete();
      end else if (pkt.size() > 0) pkt.push_back(b);
      if (pkt.size() > 0 && pkt.size() == plen(pkt[0])) begin
        done = 1;
        t = pkt[0] == 8'h90 ? 2'd0 : pkt[0] == 8'h80 ? 2'd1 : pkt[0] == 8'hE0 ? 2'd2 : 2'd3;
        c = {t, pkt.size() > 1 ? pkt[1][3:0] : 4'd0, pkt.size() == 4 ? pkt[2][6:0] : 7'd0,
             pkt.size() == 4 ? pkt[3][6:0] : 7'd0};
        pkt.delete();
      end
    end
    if (done) begin
      if (mocc < D || pop) begin
        expq.push_back(c);
        mocc++;
      end else begin
        ovf_exp = 1;
        e = 1;
      end
    end
    if (pop) mocc--;
    if (e && err_exp < 255) err_exp++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00);
  endtask

  task automatic do_reset();
    i_reset = 1;
    i_byte_valid = 0;
    i_byte = 0;
    i_cmd_ready = 0;
    expq.delete();
    pkt.delete();
    mocc = 0;
    err_exp = 0;
    ovf_exp = 0;
    gap = 0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid"}, o_cmd_valid, 0);
    chk({nm, "_fields"}, got, 0);
    chk({nm, "_overflow"}, o_overflow, 0);
    chk({nm, "_err"}, o_err_count, 0);
  endtask

  initial begin
    logic [7:0] b;
    do_reset();
    chk_reset_state("reset");
    rdy = 1;
    tick(1, 8'h90); tick(1, 8'h05); tick(1, 8'h3C);
    chk("noteon_not_early", o_cmd_valid, 0);
    tick(1, 8'h64);
    chk("noteon_valid", o_cmd_valid, 1);
    chk("noteon_fields", got, {2'd0, 4'd5, 7'h3C, 7'h64});
    idle(3);
    chk("noteon_err", o_err_count, 0);
    tick(1, 8'h80); tick(1, 8'h03); tick(1, 8'hB0);
    chk("alloff_valid", o_cmd_valid, 1);
    chk("alloff_type", o_cmd_type, 3);
    idle(3);
    chk("noteoff_alloff_err", o_err_count, 0);
    do_reset();
    rdy = 1;
    foreach (pkt[i]) pkt.delete();
    tick(1, 8'h90); tick(1, 8'h02); tick(1, 8'h90); tick(1, 8'h01); tick(1, 8'h40); tick(1, 8'h7F);
    idle(3);
    chk("resync_err", o_err_count, 1);
    tick(1, 8'h90); tick(1, 8'h10);
    idle(3);
    chk("voice_range_err", o_err_count, 2);
    tick(1, 8'h80); tick(1, 8'h0F);
    idle(3);
    chk("voice_max_err", o_err_count, 2);
    do_reset();
    rdy = 1;
    tick(1, 8'hE0); tick(1, 8'h04);
    idle(TO);
    tick(1, 8'h00); tick(1, 8'h40);
    idle(3);
    chk("timeout_err", o_err_count, 1);
    tick(1, 8'hE0); tick(1, 8'h04);
    idle(TO - 1);
    tick(1, 8'h00); tick(1, 8'h40);
    idle(3);
    chk("no_timeout_err", o_err_count, 1);
    do_reset();
    rdy = 0;
    for (int i = 0; i <= D; i++) begin
      tick(1, 8'h80);
      tick(1, 8'(i));
    end
    idle(2);
    chk("bp_overflow", o_overflow, 1);
    chk("bp_err", o_err_count, 1);
    chk("bp_head", got, {2'd1, 4'd0, 14'd0});
    rdy = 1;
    idle(D + 3);
    chk("bp_drained", o_cmd_valid, 0);
    rdy = 0;
    tick(1, 8'h80); tick(1, 8'h02); tick(1, 8'h90); tick(1, 8'h05);
    chk("pre_reset_valid", o_cmd_valid, 1);
    do_reset();
    chk_reset_state("midreset");
    rdy = 1;
    tick(1, 8'h80); tick(1, 8'h07);
    chk("post_reset_cmd", got, {2'd1, 4'd7, 14'd0});
    idle(3);
    for (int n = 0; n < 3000; n++) begin
      rdy = n < 1500 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 99) == 0) idle(TO + $urandom_range(0, 2));
      if ($urandom_range(0, 9) < 3) tick(0, 8'h00);
      else begin
        case ($urandom_range(0, 9))
          0: b = 8'h90;
          1: b = 8'h80;
          2: b = 8'hE0;
          3: b = 8'hB0;
          4: b = {1'b1, 7'($urandom_range(0, 127))};
          default: b = $urandom_range(0, 1) != 0 ? 8'($urandom_range(0, 19)) : 8'($urandom_range(0, 127));
        endcase
        tick(1, b);
      end
    end
    rdy = 1;
    idle(TO + 5);
    chk("final_queue_empty", expq.size(), 0);
    chk("final_valid", o_cmd_valid, 0);
    chk("final_err", o_err_count, err_exp);
    chk("final_overflow", o_overflow, ovf_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
